// File: rtl/clint_responder_pkg.sv
// Shared definitions for the CLINT timer responder: register offsets,
// response codes, FSM encodings and address/strobe helpers.
package clint_responder_pkg;

    localparam logic [31:0] OFF_MTIME_LO = 32'h0;
    localparam logic [31:0] OFF_MTIME_HI = 32'h4;
    localparam logic [31:0] OFF_CMP_LO   = 32'h8;
    localparam logic [31:0] OFF_CMP_HI   = 32'hC;

    localparam logic RESP_OK  = 1'b0;
    localparam logic RESP_ERR = 1'b1;

    typedef enum logic {R_IDLE = 1'b0, R_RESP = 1'b1} rd_state_t;
    typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wr_state_t;

    typedef enum logic [1:0] {
        REG_MTIME_LO = 2'd0,
        REG_MTIME_HI = 2'd1,
        REG_CMP_LO   = 2'd2,
        REG_CMP_HI   = 2'd3
    } reg_sel_t;

    typedef struct packed {
        logic     err;
        reg_sel_t sel;
    } dec_t;

    // The window base need not be 16-byte aligned, so decode on the offset.
    function automatic dec_t decode(input logic [31:0] addr, input logic [31:0] base);
        logic [31:0] off;
        dec_t        d;
        off   = addr - base;
        d.err = 1'b0;
        d.sel = REG_MTIME_LO;
        case (off)
            OFF_MTIME_LO: d.sel = REG_MTIME_LO;
            OFF_MTIME_HI: d.sel = REG_MTIME_HI;
            OFF_CMP_LO:   d.sel = REG_CMP_LO;
            OFF_CMP_HI:   d.sel = REG_CMP_HI;
            default:      d.err = 1'b1;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/clint_mtime_counter.sv
// Prescaled free-running 64-bit mtime with byte-masked software load.
// A load in the same cycle as a tick wins and the tick is dropped.
module clint_mtime_counter
    import clint_responder_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load_lo,
    input  logic        i_load_hi,
    input  logic [31:0] i_load_data,
    input  logic [3:0]  i_load_strb,
    output logic [63:0] o_mtime
);

    localparam int             PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX  = PW'(DIV - 1);

    logic [PW-1:0] r_presc;
    logic [63:0]   r_mtime;
    logic          w_tick;
    logic [31:0]   w_mask;
    logic [31:0]   w_lo;
    logic [31:0]   w_hi;

    assign w_tick = (r_presc == PRESC_MAX);
    assign w_mask = strb_mask(i_load_strb);
    assign w_lo   = (r_mtime[31:0]  & ~w_mask) | (i_load_data & w_mask);
    assign w_hi   = (r_mtime[63:32] & ~w_mask) | (i_load_data & w_mask);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
            r_mtime <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (i_load_lo || i_load_hi) begin
                if (i_load_lo) r_mtime[31:0]  <= w_lo;
                if (i_load_hi) r_mtime[63:32] <= w_hi;
            end else if (w_tick) begin
                r_mtime <= r_mtime + 64'd1;
            end
        end
    end

    assign o_mtime = r_mtime;

endmodule

// File: rtl/clint_responder.sv
// CLINT timer responder: AXI-lite-style slave exposing mtime/mtimecmp, raises mtip.
// state  | meaning
// R_IDLE | arready high, waiting for a read address
// R_RESP | rvalid/rdata/rresp held until rready
// W_IDLE | collecting AW and W in any order
// W_RESP | bvalid/bresp held until bready
module clint_responder
    import clint_responder_pkg::*;
#(
    parameter logic [31:0] BASE = 32'ha000_0048,
    parameter int          DIV  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic        rresp,
    output logic        rvalid,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [31:0] wstrb,
    input  logic        wvalid,
    output logic        wready,
    input  logic        bready,
    output logic        bresp,
    output logic        bvalid,
    output logic        mtip
);

    logic [63:0] w_mtime;
    logic [63:0] r_mtimecmp;
    logic [31:0] r_shadow;
    logic        r_mtip;

    rd_state_t   r_rd_state;
    logic        r_arready, r_rvalid, r_rresp;
    logic [31:0] r_rdata;
    dec_t        w_rd_dec;
    logic [31:0] w_rd_word;

    wr_state_t   r_wr_state;
    logic        r_aw_got, r_w_got;
    logic [31:0] r_awaddr, r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_awready, r_wready, r_bvalid, r_bresp;
    logic        w_aw_hs, w_w_hs, w_do_write, w_wr_ok;
    logic [31:0] w_wr_addr, w_wr_data;
    logic [3:0]  w_wr_strb;
    logic [31:0] w_cmp_mask;
    dec_t        w_wr_dec;
    logic        w_unused_strb;

    assign w_unused_strb = ^wstrb[31:4];

    // Read side: reads see register values from before any same-cycle write.
    assign w_rd_dec = decode(araddr, BASE);

    always_comb begin
        w_rd_word = '0;
        case (w_rd_dec.sel)
            REG_MTIME_LO: w_rd_word = w_mtime[31:0];
            REG_MTIME_HI: w_rd_word = r_shadow;
            REG_CMP_LO:   w_rd_word = r_mtimecmp[31:0];
            REG_CMP_HI:   w_rd_word = r_mtimecmp[63:32];
            default:      w_rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_state <= R_IDLE;
            r_arready  <= 1'b1;
            r_rvalid   <= 1'b0;
            r_rresp    <= RESP_OK;
            r_rdata    <= '0;
            r_shadow   <= '0;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (arvalid && r_arready) begin
                        r_arready  <= 1'b0;
                        r_rvalid   <= 1'b1;
                        r_rresp    <= w_rd_dec.err ? RESP_ERR : RESP_OK;
                        r_rdata    <= w_rd_dec.err ? 32'h0 : w_rd_word;
                        if (!w_rd_dec.err && w_rd_dec.sel == REG_MTIME_LO)
                            r_shadow <= w_mtime[63:32];
                        r_rd_state <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        r_rvalid   <= 1'b0;
                        r_arready  <= 1'b1;
                        r_rd_state <= R_IDLE;
                    end
                end
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    // Write side: the beat completing the pair is used directly so the
    // register updates on the same edge that captures it.
    assign w_aw_hs    = awvalid && r_awready;
    assign w_w_hs     = wvalid && r_wready;
    assign w_wr_addr  = r_aw_got ? r_awaddr : awaddr;
    assign w_wr_data  = r_w_got  ? r_wdata  : wdata;
    assign w_wr_strb  = r_w_got  ? r_wstrb  : wstrb[3:0];
    assign w_do_write = (r_wr_state == W_IDLE) && (r_aw_got || w_aw_hs) && (r_w_got || w_w_hs);
    assign w_wr_dec   = decode(w_wr_addr, BASE);
    assign w_wr_ok    = w_do_write && !w_wr_dec.err;
    assign w_cmp_mask = strb_mask(w_wr_strb);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_state <= W_IDLE;
            r_aw_got   <= 1'b0;
            r_w_got    <= 1'b0;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_awready  <= 1'b1;
            r_wready   <= 1'b1;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OK;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_aw_got  <= 1'b1;
                        r_awaddr  <= awaddr;
                        r_awready <= 1'b0;
                    end
                    if (w_w_hs) begin
                        r_w_got  <= 1'b1;
                        r_wdata  <= wdata;
                        r_wstrb  <= wstrb[3:0];
                        r_wready <= 1'b0;
                    end
                    if (w_do_write) begin
                        r_bvalid   <= 1'b1;
                        r_bresp    <= w_wr_dec.err ? RESP_ERR : RESP_OK;
                        r_wr_state <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        r_bvalid   <= 1'b0;
                        r_awready  <= 1'b1;
                        r_wready   <= 1'b1;
                        r_aw_got   <= 1'b0;
                        r_w_got    <= 1'b0;
                        r_wr_state <= W_IDLE;
                    end
                end
                default: r_wr_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mtimecmp <= '1;
            r_mtip     <= 1'b0;
        end else begin
            if (w_wr_ok && w_wr_dec.sel == REG_CMP_LO)
                r_mtimecmp[31:0] <= (r_mtimecmp[31:0] & ~w_cmp_mask) | (w_wr_data & w_cmp_mask);
            if (w_wr_ok && w_wr_dec.sel == REG_CMP_HI)
                r_mtimecmp[63:32] <= (r_mtimecmp[63:32] & ~w_cmp_mask) | (w_wr_data & w_cmp_mask);
            r_mtip <= (w_mtime >= r_mtimecmp);
        end
    end

    clint_mtime_counter #(.DIV(DIV)) u_mtime (
        .clk         (clk),
        .rst         (rst),
        .i_load_lo   (w_wr_ok && w_wr_dec.sel == REG_MTIME_LO),
        .i_load_hi   (w_wr_ok && w_wr_dec.sel == REG_MTIME_HI),
        .i_load_data (w_wr_data),
        .i_load_strb (w_wr_strb),
        .o_mtime     (w_mtime)
    );

    assign arready = r_arready;
    assign rvalid  = r_rvalid;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;
    assign awready = r_awready;
    assign wready  = r_wready;
    assign bvalid  = r_bvalid;
    assign bresp   = r_bresp;
    assign mtip    = r_mtip;

endmodule

// File: tb/tb_clint_responder.sv
// Directed bench for clint_responder: counting, shadowed reads, write ordering,
// interrupt timing, error responses, back-pressure and mid-transaction reset.
module tb_clint_responder;
    import clint_responder_pkg::*;

    localparam logic [31:0] BASE = 32'ha000_0048;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic        rready = 1'b1;
    logic [31:0] rdata;
    logic        rresp;
    logic        rvalid;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [31:0] wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic        bready = 1'b1;
    logic        bresp;
    logic        bvalid;
    logic        mtip;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    clint_responder #(.BASE(BASE), .DIV(1)) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rready(rready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bready(bready), .bresp(bresp), .bvalid(bvalid),
        .mtip(mtip)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] off, output logic [31:0] data, output logic resp);
        int n;
        araddr  = BASE + off;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin tick; n++; end
        chk("ar_wait", 64'(n < 20), 64'd1);
        tick;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin tick; n++; end
        chk("r_wait", 64'(n < 20), 64'd1);
        data = rdata;
        resp = rresp;
        tick;
    endtask

    // mode 0: AW and W together, 1: W one cycle before AW, 2: AW before W
    task automatic wr(input logic [31:0] off, input logic [31:0] data, input logic [3:0] strb,
                      input int mode, output logic resp);
        int n;
        awaddr = BASE + off;
        wdata  = data;
        wstrb  = {28'h0, strb};
        n = 0;
        while (!(awready && wready) && n < 20) begin tick; n++; end
        chk("aw_w_wait", 64'(n < 20), 64'd1);
        if (mode == 1) begin
            wvalid = 1'b1; tick; wvalid = 1'b0;
            chk("w_first_hold", 64'({bvalid, wready, awready}), 64'b001);
            awvalid = 1'b1; tick; awvalid = 1'b0;
        end else if (mode == 2) begin
            awvalid = 1'b1; tick; awvalid = 1'b0;
            chk("aw_first_hold", 64'({bvalid, awready, wready}), 64'b001);
            wvalid = 1'b1; tick; wvalid = 1'b0;
        end else begin
            awvalid = 1'b1; wvalid = 1'b1; tick; awvalid = 1'b0; wvalid = 1'b0;
        end
        chk("bvalid", 64'(bvalid), 64'd1);
        resp = bresp;
        tick;
        chk("b_single", 64'(bvalid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic        r;

        #12;
        chk("rst_ready", 64'({arready, awready, wready}), 64'b111);
        chk("rst_valid", 64'({rvalid, bvalid, mtip}), 64'b000);
        chk("rst_data", 64'({rdata, rresp, bresp}), 64'd0);
        tick;
        rst = 1'b1;

        // mtime counts once per cycle from the first edge after release
        repeat (10) tick;
        rd(OFF_MTIME_LO, d, r);
        chk("cnt_after_rst", 64'(d), 64'd10);
        chk("cnt_resp", 64'(r), 64'd0);

        wr(OFF_CMP_LO, 32'h11, 4'hF, 0, r);
        chk("wr_same_resp", 64'(r), 64'd0);
        rd(OFF_CMP_LO, d, r);
        chk("wr_same_rb", 64'(d), 64'h11);
        wr(OFF_CMP_LO, 32'h20, 4'hF, 1, r);
        chk("wr_wfirst_resp", 64'(r), 64'd0);
        rd(OFF_CMP_LO, d, r);
        chk("wr_wfirst_rb", 64'(d), 64'h20);
        wr(OFF_CMP_LO, 32'hAABB_CCDD, 4'h2, 2, r);
        chk("wr_awfirst_resp", 64'(r), 64'd0);
        rd(OFF_CMP_LO, d, r);
        chk("wr_strb_rb", 64'(d), 64'h0000_CC20);
        wr(OFF_CMP_LO, 32'h20, 4'hF, 0, r);
        rd(OFF_CMP_HI, d, r);
        chk("cmp_hi_reset", 64'(d), 64'hFFFF_FFFF);

        // lo-then-hi read across a rollover returns the shadowed hi word
        wr(OFF_MTIME_HI, 32'h0, 4'hF, 0, r);
        awaddr = BASE + OFF_MTIME_LO; wdata = 32'hFFFF_FFFE; wstrb = 32'hF;
        awvalid = 1'b1; wvalid = 1'b1; tick; awvalid = 1'b0; wvalid = 1'b0;
        araddr = BASE + OFF_MTIME_LO; arvalid = 1'b1; tick; arvalid = 1'b0;
        chk("snap_lo", 64'({rvalid, rdata}), {31'h0, 1'b1, 32'hFFFF_FFFE});
        tick;
        repeat (4) tick;
        rd(OFF_MTIME_HI, d, r);
        chk("snap_hi_shadow", 64'(d), 64'h0);
        rd(OFF_MTIME_LO, d, r);
        rd(OFF_MTIME_HI, d, r);
        chk("snap_hi_rolled", 64'(d), 64'h1);

        // interrupt
        wr(OFF_CMP_LO, 32'h30, 4'hF, 0, r);
        wr(OFF_MTIME_LO, 32'h0, 4'hF, 0, r);
        wr(OFF_MTIME_HI, 32'h0, 4'hF, 0, r);
        wr(OFF_CMP_HI, 32'h0, 4'hF, 0, r);
        chk("mtip_low", 64'(mtip), 64'd0);
        awaddr = BASE + OFF_MTIME_LO; wdata = 32'h2E; wstrb = 32'hF;
        awvalid = 1'b1; wvalid = 1'b1; tick; awvalid = 1'b0; wvalid = 1'b0;
        chk("mtip_2e_a", 64'(mtip), 64'd0);
        tick;
        chk("mtip_2e_b", 64'(mtip), 64'd0);
        tick;
        chk("mtip_2f", 64'(mtip), 64'd0);
        tick;
        chk("mtip_rise", 64'(mtip), 64'd1);
        tick;
        awaddr = BASE + OFF_CMP_HI; wdata = 32'h1; wstrb = 32'hF;
        awvalid = 1'b1; wvalid = 1'b1; tick; awvalid = 1'b0; wvalid = 1'b0;
        chk("mtip_hold", 64'(mtip), 64'd1);
        tick;
        chk("mtip_drop", 64'(mtip), 64'd0);
        tick;

        // error and back-pressure
        rd(32'h10, d, r);
        chk("err_rd", 64'({r, d}), {31'h0, 1'b1, 32'h0});
        rready = 1'b0;
        araddr = BASE + OFF_CMP_LO; arvalid = 1'b1; tick; arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", 64'({rvalid, arready, rdata}), {30'h0, 2'b10, 32'h30});
            tick;
        end
        rready = 1'b1;
        tick;
        chk("bp_done", 64'({rvalid, arready}), 64'b01);
        wr(32'h2, 32'hDEAD_BEEF, 4'hF, 0, r);
        chk("err_wr_resp", 64'(r), 64'd1);
        rd(OFF_CMP_LO, d, r);
        chk("err_wr_cmp_lo", 64'(d), 64'h30);
        rd(OFF_CMP_HI, d, r);
        chk("err_wr_cmp_hi", 64'(d), 64'h1);

        // reset after AW captured, with a read response also pending
        rready = 1'b0;
        awaddr = BASE + OFF_CMP_LO; awvalid = 1'b1;
        araddr = BASE + OFF_CMP_LO; arvalid = 1'b1;
        tick;
        awvalid = 1'b0; arvalid = 1'b0;
        chk("mid_pending", 64'({awready, rvalid}), 64'b01);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_ready", 64'({arready, awready, wready}), 64'b111);
        chk("mid_rst_valid", 64'({rvalid, bvalid, mtip}), 64'b000);
        chk("mid_rst_data", 64'({rdata, rresp, bresp}), 64'd0);
        rready = 1'b1;
        tick;
        rst = 1'b1;
        tick;
        rd(OFF_CMP_LO, d, r);
        chk("post_rst_cmp", 64'(d), 64'hFFFF_FFFF);
        wr(OFF_CMP_LO, 32'h55, 4'hF, 0, r);
        chk("post_rst_wr", 64'(r), 64'd0);
        rd(OFF_CMP_LO, d, r);
        chk("post_rst_rb", 64'(d), 64'h55);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
